// File: rtl/div_ratio_ctrl.sv
// Ratio control ahead of the odd/even divider cores: validates a requested ratio,
// maps it to a load value and core select, and sequences divider reset/enable and lock.
`ifndef SIZE
`define SIZE 8
`endif

module div_ratio_ctrl #(
   parameter int unsigned SETTLE_EXTRA = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             req_valid,
   input  logic [`SIZE-1:0] req_ratio,
   output logic             req_ready,
   output logic [`SIZE-1:0] P,
   output logic             odd_sel,
   output logic             div_reset,
   output logic             div_enable,
   output logic             locked,
   output logic             err
);

   localparam int unsigned W  = `SIZE;
   localparam int unsigned CW = W + 1;

   typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  ratio_q, ratio_nxt, p_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          odd_nxt, rdy_nxt, drst_nxt, err_nxt;
   logic          en_q, en_nxt, lock_q, lock_nxt;
   logic          accept, legal;

   assign accept = req_valid & req_ready;
   assign legal  = (req_ratio >= W'(2));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and next values of every registered output
   always_comb begin
      state_nxt = state;
      ratio_nxt = ratio_q;
      p_nxt     = P;
      odd_nxt   = odd_sel;
      cnt_nxt   = cnt_q;
      err_nxt   = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (accept) begin
               if (!legal) begin
                  err_nxt = 1'b1;
               end else if ((state == IDLE) || (req_ratio != ratio_q)) begin
                  state_nxt = APPLY;
                  ratio_nxt = req_ratio;
                  odd_nxt   = req_ratio[0];
                  p_nxt     = req_ratio[0] ? req_ratio : (req_ratio >> 1);
               end
            end
         end
         APPLY: begin
            cnt_nxt   = CW'(ratio_q) + CW'(SETTLE_EXTRA);
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (run_en) begin
               cnt_nxt = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
      rdy_nxt  = (state_nxt == IDLE) || (state_nxt == RUN);
      drst_nxt = (state_nxt == IDLE) || (state_nxt == APPLY);
      en_nxt   = (state_nxt == SETTLE) || (state_nxt == RUN);
      lock_nxt = (state_nxt == RUN);
   end

   // Output and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ratio_q   <= '0;
         cnt_q     <= '0;
         P         <= '0;
         odd_sel   <= 1'b0;
         req_ready <= 1'b1;
         div_reset <= 1'b1;
         en_q      <= 1'b0;
         lock_q    <= 1'b0;
         err       <= 1'b0;
      end else begin
         ratio_q   <= ratio_nxt;
         cnt_q     <= cnt_nxt;
         P         <= p_nxt;
         odd_sel   <= odd_nxt;
         req_ready <= rdy_nxt;
         div_reset <= drst_nxt;
         en_q      <= en_nxt;
         lock_q    <= lock_nxt;
         err       <= err_nxt;
      end
   end

   // Global run enable gates the core enable and lock without a cycle of lag
   assign div_enable = en_q & run_en;
   assign locked     = lock_q & run_en;

endmodule
